bus_divide_unit: RTL and testbench

- Memory-mapped, multi-cycle integer divider.
- Acts as a responder on the shared processor bus (Clk, address, nRead, nWrite, 256-bit data) alongside main memory and the integer and matrix ALUs.
- Execution writes the operands, polls status, then reads back the quotient and remainder.
- Uses restoring division, one quotient bit per cycle.

---
 rtl/bus_divide_pkg.sv | 34 +++
 rtl/bus_divide_unit_div_core.sv | 104 ++++++++++
 rtl/bus_divide_unit.sv | 109 ++++++++++
 tb/tb_bus_divide_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_divide_pkg.sv
// Shared constants, state encoding and status packing for the bus divide unit.
package bus_divide_pkg;

  localparam logic [3:0] DEFAULT_DEV_ID = 4'h5;

  localparam logic [3:0] OFF_DIVIDEND  = 4'd0;
  localparam logic [3:0] OFF_DIVISOR   = 4'd1;
  localparam logic [3:0] OFF_QUOTIENT  = 4'd2;
  localparam logic [3:0] OFF_REMAINDER = 4'd3;
  localparam logic [3:0] OFF_STATUS    = 4'd4;

  localparam int STAT_BUSY        = 0;
  localparam int STAT_DONE        = 1;
  localparam int STAT_DIV_BY_ZERO = 2;
  localparam int STAT_OVERRUN     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } divState_t;

  function automatic logic [3:0] packStatus(input logic busy, input logic done,
                                            input logic divByZero, input logic overrun);
    logic [3:0] s;
    s                   = 4'd0;
    s[STAT_BUSY]        = busy;
    s[STAT_DONE]        = done;
    s[STAT_DIV_BY_ZERO] = divByZero;
    s[STAT_OVERRUN]     = overrun;
    return s;
  endfunction

endpackage

// File: rtl/bus_divide_unit_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// A zero divisor skips the iteration and finishes on the next edge.
module div_core
  import bus_divide_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             divByZero
);

  localparam int CW = $clog2(WIDTH + 1);

  divState_t        state;
  logic [WIDTH:0]   partRem;
  logic [WIDTH-1:0] shiftReg;
  logic [WIDTH-1:0] divisorReg;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   trialRem;
  logic [WIDTH:0]   nextRem;
  logic             qBit;

  // One shift/subtract step; dividend bits leave shiftReg as quotient bits enter it.
  always_comb begin
    trialRem = {partRem[WIDTH-1:0], shiftReg[WIDTH-1]};
    if (trialRem >= {1'b0, divisorReg}) begin
      nextRem = trialRem - {1'b0, divisorReg};
      qBit    = 1'b1;
    end else begin
      nextRem = trialRem;
      qBit    = 1'b0;
    end
  end

  // Divider sequencer with registered busy/done/divByZero flags.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state      <= IDLE;
      partRem    <= '0;
      shiftReg   <= '0;
      divisorReg <= '0;
      count      <= '0;
      quotient   <= '0;
      remainder  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      divByZero  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == '0) begin
              state     <= DONE;
              quotient  <= '1;
              remainder <= dividend;
              busy      <= 1'b0;
              done      <= 1'b1;
              divByZero <= 1'b1;
            end else begin
              state      <= CALC;
              partRem    <= '0;
              shiftReg   <= dividend;
              divisorReg <= divisor;
              count      <= CW'(WIDTH);
              busy       <= 1'b1;
              done       <= 1'b0;
              divByZero  <= 1'b0;
            end
          end else begin
            state <= state;
          end
        end
        CALC: begin
          partRem  <= nextRem;
          shiftReg <= {shiftReg[WIDTH-2:0], qBit};
          count    <= count - CW'(1);
          if (count == CW'(1)) begin
            state     <= DONE;
            quotient  <= {shiftReg[WIDTH-2:0], qBit};
            remainder <= nextRem[WIDTH-1:0];
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            state <= CALC;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bus_divide_unit.sv
// Memory-mapped divider responder: bus decode, operand registers, STATUS and
// a registered read port in front of the iterative div_core.
module bus_divide_unit
  import bus_divide_pkg::*;
#(
  parameter int         WIDTH  = 32,
  parameter logic [3:0] DEV_ID = DEFAULT_DEV_ID
) (
  input  logic         Clk,
  input  logic         nReset,
  output logic [255:0] DataOut,
  input  logic [255:0] DataIn,
  input  logic [15:0]  address,
  input  logic         nRead,
  input  logic         nWrite
);

  logic             sel;
  logic [3:0]       offset;
  logic             wrEn;
  logic             rdEn;
  logic             operandWrite;
  logic             startReq;
  logic [WIDTH-1:0] wrData;
  logic [WIDTH-1:0] dividendReg;
  logic [WIDTH-1:0] divisorReg;
  logic             overrunReg;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             coreBusy;
  logic             coreDone;
  logic             coreDivByZero;
  logic [255:0]     readMux;
  logic             unusedBits;

  assign sel          = (address[15:12] == DEV_ID);
  assign offset       = address[3:0];
  assign wrEn         = sel & ~nWrite;
  assign rdEn         = sel & ~nRead;
  assign wrData       = DataIn[WIDTH-1:0];
  assign operandWrite = wrEn & ((offset == OFF_DIVIDEND) | (offset == OFF_DIVISOR));
  assign startReq     = wrEn & (offset == OFF_DIVISOR) & ~coreBusy;
  assign unusedBits   = ^{DataIn[255:WIDTH], address[11:4]};

  div_core #(.WIDTH(WIDTH)) u_core (
    .clk       (Clk),
    .nReset    (nReset),
    .start     (startReq),
    .dividend  (dividendReg),
    .divisor   (wrData),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (coreBusy),
    .done      (coreDone),
    .divByZero (coreDivByZero)
  );

  // Operand registers and overrun flag; operand writes are locked out while busy.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      dividendReg <= '0;
      divisorReg  <= '0;
      overrunReg  <= 1'b0;
    end else begin
      if (wrEn && (offset == OFF_DIVIDEND) && !coreBusy) begin
        dividendReg <= wrData;
      end else begin
        dividendReg <= dividendReg;
      end
      if (startReq) begin
        divisorReg <= wrData;
      end else begin
        divisorReg <= divisorReg;
      end
      if (operandWrite && coreBusy) begin
        overrunReg <= 1'b1;
      end else if (startReq) begin
        overrunReg <= 1'b0;
      end else begin
        overrunReg <= overrunReg;
      end
    end
  end

  // Read data selection from pre-edge register values.
  always_comb begin
    readMux = '0;
    case (offset)
      OFF_DIVIDEND:  readMux[WIDTH-1:0] = dividendReg;
      OFF_DIVISOR:   readMux[WIDTH-1:0] = divisorReg;
      OFF_QUOTIENT:  readMux[WIDTH-1:0] = quotient;
      OFF_REMAINDER: readMux[WIDTH-1:0] = remainder;
      OFF_STATUS:    readMux[3:0]       = packStatus(coreBusy, coreDone, coreDivByZero, overrunReg);
      default:       readMux            = '0;
    endcase
  end

  // Registered read port; idle bus cycles return zero.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      DataOut <= '0;
    end else if (rdEn) begin
      DataOut <= readMux;
    end else begin
      DataOut <= '0;
    end
  end

endmodule

// File: tb/tb_bus_divide_unit.sv
// Directed and randomized checks of bus_divide_unit against arithmetic expectations.
module tb_bus_divide_unit;

  localparam logic [3:0] DEV   = 4'h5;
  localparam logic [3:0] OTHER = 4'h2;
  localparam logic [3:0] R_DVD = 4'd0;
  localparam logic [3:0] R_DVS = 4'd1;
  localparam logic [3:0] R_QUO = 4'd2;
  localparam logic [3:0] R_REM = 4'd3;
  localparam logic [3:0] R_STA = 4'd4;

  logic         Clk;
  logic         nReset;
  logic [255:0] DataOut;
  logic [255:0] DataIn;
  logic [15:0]  address;
  logic         nRead;
  logic         nWrite;

  int compared;
  int mismatched;

  bus_divide_unit #(.WIDTH(32), .DEV_ID(4'h5)) dut (
    .Clk     (Clk),
    .nReset  (nReset),
    .DataOut (DataOut),
    .DataIn  (DataIn),
    .address (address),
    .nRead   (nRead),
    .nWrite  (nWrite)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic busIdle();
    nRead   = 1'b1;
    nWrite  = 1'b1;
    address = 16'h0000;
    DataIn  = 256'd0;
  endtask

  task automatic writeReg(input logic [3:0] dev, input logic [3:0] off, input logic [31:0] data);
    address = {dev, 8'h00, off};
    DataIn  = {{7{32'hdeadbeef}}, data};
    nWrite  = 1'b0;
    tick();
    busIdle();
  endtask

  task automatic readReg(input logic [3:0] dev, input logic [3:0] off, output logic [255:0] val);
    address = {dev, 8'h00, off};
    nRead   = 1'b0;
    tick();
    val = DataOut;
    busIdle();
  endtask

  task automatic readCheck(input string tag, input logic [3:0] off, input logic [31:0] exp);
    logic [255:0] v;
    readReg(DEV, off, v);
    check(tag, v, {224'd0, exp});
  endtask

  // Poll STATUS, counting busy samples, then compare count and final status.
  task automatic waitDone(input int expBusy, input logic [3:0] expStatus, input string tag);
    logic [255:0] v;
    int busyReads;
    busyReads = 0;
    v = '0;
    for (int i = 0; i < 60; i++) begin
      readReg(DEV, R_STA, v);
      if (v[0] === 1'b1) busyReads++;
      else break;
    end
    check({tag, "_busy_cycles"}, 256'(busyReads), 256'(expBusy));
    check({tag, "_status"}, v, {252'd0, expStatus});
  endtask

  task automatic doDivide(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] q;
    logic [31:0] r;
    q = (b == 32'd0) ? 32'hffffffff : a / b;
    r = (b == 32'd0) ? a : a % b;
    writeReg(DEV, R_DVD, a);
    writeReg(DEV, R_DVS, b);
    waitDone((b == 32'd0) ? 0 : 32, (b == 32'd0) ? 4'h6 : 4'h2, tag);
    readCheck({tag, "_quot"}, R_QUO, q);
    readCheck({tag, "_rem"}, R_REM, r);
    readCheck({tag, "_dvd"}, R_DVD, a);
    readCheck({tag, "_dvs"}, R_DVS, b);
  endtask

  initial begin
    logic [255:0] v;
    logic [31:0]  a;
    logic [31:0]  b;
    compared   = 0;
    mismatched = 0;
    busIdle();
    nReset = 1'b0;
    tick();
    tick();
    check("reset_dataout", DataOut, 256'd0);
    nReset = 1'b1;
    readCheck("reset_status", R_STA, 32'h0);
    readCheck("reset_quot", R_QUO, 32'h0);
    readCheck("reset_dvd", R_DVD, 32'h0);

    // 100 / 7 with exact busy window, then read latency and clear-after-read.
    doDivide(32'd100, 32'd7, "div100_7");
    address = {DEV, 8'h00, R_QUO};
    nRead   = 1'b0;
    @(posedge Clk);
    #1;
    check("read_latency", DataOut, 256'd14);
    busIdle();
    tick();
    check("read_clears", DataOut, 256'd0);
    readCheck("unmapped_offset", 4'd9, 32'h0);

    // Divide by zero finishes on the next edge.
    doDivide(32'd55, 32'd0, "div55_0");

    // Overrun: dividend write at cycle 10 of an active divide is dropped.
    writeReg(DEV, R_DVD, 32'hffffffff);
    writeReg(DEV, R_DVS, 32'd1);
    repeat (9) tick();
    writeReg(DEV, R_DVD, 32'd3);
    waitDone(22, 4'hA, "overrun");
    readCheck("overrun_quot", R_QUO, 32'hffffffff);
    readCheck("overrun_rem", R_REM, 32'h0);
    readCheck("overrun_dvd", R_DVD, 32'hffffffff);
    doDivide(32'hffffffff, 32'd2, "overrun_clear");

    // Reset in the middle of 1000 / 3, with a read strobe during reset.
    writeReg(DEV, R_DVD, 32'd1000);
    writeReg(DEV, R_DVS, 32'd3);
    repeat (4) tick();
    nReset  = 1'b0;
    address = {DEV, 8'h00, R_STA};
    nRead   = 1'b0;
    tick();
    check("midreset_dataout", DataOut, 256'd0);
    busIdle();
    nReset = 1'b1;
    readCheck("midreset_status", R_STA, 32'h0);
    readCheck("midreset_quot", R_QUO, 32'h0);
    readCheck("midreset_rem", R_REM, 32'h0);
    readCheck("midreset_dvd", R_DVD, 32'h0);
    readCheck("midreset_dvs", R_DVS, 32'h0);
    doDivide(32'd9, 32'd3, "div9_3");

    // Accesses for another device must be ignored.
    readReg(OTHER, R_QUO, v);
    check("other_dev_read", v, 256'd0);
    writeReg(OTHER, R_DVD, 32'd77);
    readCheck("other_dev_wr_dvd", R_DVD, 32'd9);
    writeReg(OTHER, R_DVS, 32'd4);
    readCheck("other_dev_wr_status", R_STA, 32'h2);
    readCheck("other_dev_wr_dvs", R_DVS, 32'd3);

    // Back-to-back reuse of the dividend, then simultaneous read+write.
    doDivide(32'd20, 32'd6, "div20_6");
    writeReg(DEV, R_DVS, 32'd5);
    waitDone(32, 4'h2, "div20_5");
    readCheck("div20_5_quot", R_QUO, 32'd4);
    readCheck("div20_5_rem", R_REM, 32'd0);
    address = {DEV, 8'h00, R_DVD};
    DataIn  = 256'd123;
    nRead   = 1'b0;
    nWrite  = 1'b0;
    tick();
    check("rw_same_cycle_old", DataOut, 256'd20);
    busIdle();
    readCheck("rw_same_cycle_new", R_DVD, 32'd123);

    // Randomized operands against plain arithmetic.
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      if (i % 3 == 0) a = a >> $urandom_range(0, 31);
      case (i % 4)
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      doDivide(a, b, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
